d_latch: RTL and testbench
==========================

D_LATCH -- requirements
Module: d_latch

Interface
REQ-001 Parameter N, default 4: data width in bits, legal range 1..64.
REQ-002 Parameter RESET_VAL, default all-zeros (N bits): value loaded into out_q while reset is asserted.
REQ-003 Parameter EN_HIGH, default 1: 1 = transparent while clk high; 0 = transparent while clk low.
REQ-004 clk  input  1  latch enable (level-sensitive gate, not an edge clock).
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in_d  input  N  data input.
REQ-007 out_q  output  N  latched data output.

Function
REQ-008 Transparent phase (clk at the active level per EN_HIGH, reset high): out_q SHALL follow in_d combinationally, with zero cycles latency.
REQ-009 Hold phase (clk at the inactive level, reset high): out_q SHALL retain the value present at the transparent-to-hold transition.
REQ-010 in_d changes during the hold phase SHALL NOT affect out_q.
REQ-011 Hold-to-transparent transition with reset high: out_q SHALL immediately take the current in_d.
REQ-012 Each bit SHALL latch independently, with no cross-bit logic and no arithmetic.
REQ-013 Simultaneous reset assertion and transparent phase: reset SHALL win, and out_q SHALL equal RESET_VAL.
REQ-014 Reset deasserted while in the transparent phase: out_q SHALL take in_d immediately.
REQ-015 Reset deasserted while in the hold phase: out_q SHALL keep RESET_VAL until the next transparent phase.
REQ-016 The design SHALL infer level-sensitive latches, not flip-flops, and SHALL contain no combinational loops other than the latch storage.

Reset
REQ-017 reset low SHALL force out_q to RESET_VAL asynchronously, independent of clk and in_d.
REQ-018 out_q SHALL hold RESET_VAL for the whole time reset is low, including every clk phase.
REQ-019 No state other than out_q SHALL exist.

Structure
REQ-020 A shared package d_latch_pkg SHALL hold the default width constant (4) and the default reset-value constant.
REQ-021 One sub-module, d_latch_bit, SHALL implement a single-bit latch with async active-low reset and a reset-value bit. d_latch SHALL instantiate it N times in a generate loop.
REQ-022 Enable polarity SHALL be resolved once at the top level, as clk XNOR EN_HIGH, and fed to every bit.
REQ-023 The block SHALL include parameter-legality assertions (N range) and a simulation-only check that out_q equals in_d whenever the latch is transparent and out of reset.

Verification
REQ-024 Defaults. reset=0, clk=0, in_d=4'h0 -> out_q=4'h0.
REQ-025 Defaults. reset=1, clk low, in_d=4'h1 -> out_q stays 4'h0. Then clk high -> out_q=4'h1.
REQ-026 Defaults, clk high and out_q=4'h1. Drive reset=0 with in_d=4'h2 -> out_q=4'h0 immediately. Toggle clk high/low while reset=0 -> out_q stays 4'h0.
REQ-027 Defaults. reset=1 with clk low, in_d=4'h3 -> out_q stays 4'h0. Then clk high -> out_q=4'h3.
REQ-028 Defaults, clk high. Sweep in_d 4'h5 -> 4'hA -> out_q tracks each value. Then clk low and in_d=4'hF -> out_q stays 4'hA.
REQ-029 N=8, RESET_VAL=8'hA5, EN_HIGH=0. Drive reset=0 -> out_q=8'hA5. Then reset=1 with clk low and in_d=8'h3C -> out_q=8'h3C. Then clk high and in_d=8'h00 -> out_q stays 8'h3C.

Source files
------------

// File: rtl/d_latch_pkg.sv
// Shared constants for the d_latch block: default width, default reset value
// and the width ceiling used by the parameter-legality check.
package d_latch_pkg;

  localparam int unsigned DEF_N = 4;
  localparam int unsigned MIN_N = 1;
  localparam int unsigned MAX_N = 64;

  localparam logic [DEF_N-1:0] DEF_RESET_VAL = '0;

endpackage : d_latch_pkg

// File: rtl/d_latch_bit.sv
// Single-bit level-sensitive latch with asynchronous active-low reset.
// The reset value bit is an input so each instance can load its own bit of
// the parent's RESET_VAL.
module d_latch_bit (
  input  logic i_en,
  input  logic i_rst_n,
  input  logic i_rst_val,
  input  logic i_d,
  output logic o_q
);

  logic r_q;

  // Reset dominates; otherwise follow i_d while enabled and hold when not.
  always_latch begin
    if (!i_rst_n) begin
      r_q = i_rst_val;
    end else if (i_en) begin
      r_q = i_d;
    end
  end

  assign o_q = r_q;

endmodule : d_latch_bit

// File: rtl/d_latch.sv
// N-bit level-sensitive D latch built from independent single-bit latches.
// clk is a level gate, not an edge clock: EN_HIGH selects which level of clk
// makes the latch transparent. reset is asynchronous and active low.
module d_latch
  import d_latch_pkg::*;
#(
  parameter int unsigned    N         = DEF_N,
  parameter logic [N-1:0]   RESET_VAL = N'(DEF_RESET_VAL),
  parameter bit             EN_HIGH   = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] in_d,
  output logic [N-1:0] out_q
);

  // Gate polarity is resolved once here so every bit sees the same enable.
  logic         w_en;
  logic [N-1:0] w_q;

  assign w_en = clk ~^ EN_HIGH;

  // One latch per bit; no logic crosses bit boundaries.
  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    d_latch_bit u_bit (
      .i_en      (w_en),
      .i_rst_n   (reset),
      .i_rst_val (RESET_VAL[gi]),
      .i_d       (in_d[gi]),
      .o_q       (w_q[gi])
    );
  end

  assign out_q = w_q;

  // Width outside the supported range is rejected at elaboration.
  if ((N < MIN_N) || (N > MAX_N)) begin : g_bad_n
    $error("d_latch: N=%0d outside legal range %0d..%0d", N, MIN_N, MAX_N);
  end

`ifndef SYNTHESIS
  // While transparent and out of reset the output must mirror the input.
  always_comb begin
    if (reset && w_en) begin
      assert (out_q == in_d)
        else $error("d_latch: out_q %h differs from in_d %h while transparent",
                    out_q, in_d);
    end
  end
`endif

endmodule : d_latch

// File: tb/tb_d_latch.sv
// Scoreboard bench for d_latch: two instances (defaults, and N=8 / A5 /
// active-low gate). Stimulus updates a behavioural model and queues the
// expected output; a monitor process pops and compares at each sample event.
module tb_d_latch;

  typedef struct {
    int unsigned dut;
    logic [7:0]  exp;
    string       tag;
  } exp_t;

  localparam bit         A_EH = 1'b1;
  localparam logic [3:0] A_RV = 4'h0;
  localparam bit         B_EH = 1'b0;
  localparam logic [7:0] B_RV = 8'hA5;

  exp_t sb_q[$];
  event ev_sample;
  int   checks   = 0;
  int   failures = 0;

  logic       a_clk, a_rst;
  logic [3:0] a_d, a_q;
  logic       b_clk, b_rst;
  logic [7:0] b_d, b_q;

  // Reference model state: what each latch is storing right now.
  logic [3:0] ma;
  logic [7:0] mb;

  d_latch u_a (
    .clk   (a_clk),
    .reset (a_rst),
    .in_d  (a_d),
    .out_q (a_q)
  );

  d_latch #(
    .N         (8),
    .RESET_VAL (8'hA5),
    .EN_HIGH   (1'b0)
  ) u_b (
    .clk   (b_clk),
    .reset (b_rst),
    .in_d  (b_d),
    .out_q (b_q)
  );

  // Drive instance A, update its model, queue the expected output.
  task automatic drive_a(input logic rst, input logic g, input logic [3:0] d,
                         input string tag);
    exp_t e;
    a_rst = rst;
    a_clk = g;
    a_d   = d;
    if (!rst)           ma = A_RV;
    else if (g == A_EH) ma = d;
    #2;
    e.dut = 0;
    e.exp = {4'h0, ma};
    e.tag = tag;
    sb_q.push_back(e);
    ->ev_sample;
    #1;
  endtask

  // Drive instance B, update its model, queue the expected output.
  task automatic drive_b(input logic rst, input logic g, input logic [7:0] d,
                         input string tag);
    exp_t e;
    b_rst = rst;
    b_clk = g;
    b_d   = d;
    if (!rst)           mb = B_RV;
    else if (g == B_EH) mb = d;
    #2;
    e.dut = 1;
    e.exp = mb;
    e.tag = tag;
    sb_q.push_back(e);
    ->ev_sample;
    #1;
  endtask

  // Monitor: compare every queued expectation against the live output.
  initial begin
    exp_t       e;
    logic [7:0] act;
    forever begin
      @(ev_sample);
      while (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = (e.dut == 0) ? {4'h0, a_q} : b_q;
        checks++;
        if (act !== e.exp) begin
          failures++;
          $display("FAIL %s dut=%0d got=%h expected=%h", e.tag, e.dut, act, e.exp);
        end
      end
    end
  end

  initial begin
    logic       rst, g;
    logic [3:0] da;
    logic [7:0] db;
    int unsigned kind;

    ma = A_RV;
    mb = B_RV;
    a_rst = 1'b0; a_clk = 1'b0; a_d = 4'h0;
    b_rst = 1'b0; b_clk = 1'b1; b_d = 8'h00;

    // Defaults: reset, hold, transparent.
    drive_a(1'b0, 1'b0, 4'h0, "rst_default");
    drive_a(1'b1, 1'b0, 4'h1, "hold_after_rst");
    drive_a(1'b1, 1'b1, 4'h1, "open_takes_1");
    drive_a(1'b0, 1'b1, 4'h2, "rst_wins_open");
    drive_a(1'b0, 1'b0, 4'h2, "rst_gate_low");
    drive_a(1'b0, 1'b1, 4'h2, "rst_gate_high");
    drive_a(1'b0, 1'b0, 4'h2, "rst_gate_low2");
    drive_a(1'b1, 1'b0, 4'h3, "rel_in_hold");
    drive_a(1'b1, 1'b1, 4'h3, "open_takes_3");
    for (int v = 5; v <= 10; v++) drive_a(1'b1, 1'b1, 4'(v), "sweep_track");
    drive_a(1'b1, 1'b0, 4'hA, "close_keeps_A");
    drive_a(1'b1, 1'b0, 4'hF, "hold_ignores_F");
    drive_a(1'b0, 1'b1, 4'h7, "rst_again");
    drive_a(1'b1, 1'b1, 4'h6, "rel_in_open");

    // N=8, RESET_VAL=A5, gate active low.
    drive_b(1'b0, 1'b1, 8'h00, "b_rst");
    drive_b(1'b0, 1'b0, 8'h3C, "b_rst_gate_low");
    drive_b(1'b1, 1'b0, 8'h3C, "b_rel_open");
    drive_b(1'b1, 1'b1, 8'h3C, "b_close");
    drive_b(1'b1, 1'b1, 8'h00, "b_hold_ignores");

    // Randomized: one of gate / data / reset(+data) changes per step so the
    // transparent-to-hold edge never coincides with a data change.
    rst = a_rst; g = a_clk; da = a_d;
    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: g = ~g;
        1, 2: da = 4'($urandom);
        default: begin rst = ~rst; da = 4'($urandom); end
      endcase
      drive_a(rst, g, da, "rand_a");
    end

    rst = b_rst; g = b_clk; db = b_d;
    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: g = ~g;
        1, 2: db = 8'($urandom);
        default: begin rst = ~rst; db = 8'($urandom); end
      endcase
      drive_b(rst, g, db, "rand_b");
    end

    #5;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain got=%0d expected=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_d_latch
